calc_scheduler: RTL

- Shares one calculation engine (32-bit operands, 3-bit operation, edge-triggered start, level ready/error) among NUM_REQ requesters, e.g. keypad front-end and serial host.
- Round-robin arbitration; launches the engine, tracks its ready handshake with a watchdog, and returns the result to the granted requester.
- Rejects invalid operations and divide-by-zero locally, without occupying the engine.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_rr_arbiter.sv | 33 +++
 rtl/calc_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared operation codes, scheduler states and local reject rule.
package calc_pkg;

  localparam logic [2:0] OP_SUMA  = 3'd0;
  localparam logic [2:0] OP_RESTA = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_MAX   = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    REJECT,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } state_t;

  // Requests the engine cannot serve are answered locally with an error.
  function automatic logic op_rejected(input logic [2:0] op, input logic [31:0] dato_b);
    return (op > OP_MAX) || (((op == OP_DIV) || (op == OP_MOD)) && (dato_b == 32'd0));
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// rtl/calc_rr_arbiter.sv - combinational round-robin pick starting at the pointer.
module calc_rr_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [2:0]         i_ptr,
  output logic [2:0]         o_grant,
  output logic               o_any
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotating a doubled copy puts the pointer's requester at bit 0.
  assign w_dbl = {i_req_valid, i_req_valid};
  assign w_rot = NUM_REQ'(w_dbl >> i_ptr);

  always_comb begin
    o_grant = 3'd0;
    o_any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (((w_rot >> k) & ONE) != '0) begin
        o_grant = 3'((int'(i_ptr) + k) % NUM_REQ);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_scheduler.sv
// rtl/calc_scheduler.sv - shares one calculation engine among NUM_REQ requesters
// with round-robin grant, local reject, start pulse and ready watchdog.
module calc_scheduler
  import calc_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [32*NUM_REQ-1:0]  i_req_datoA,
  input  logic [32*NUM_REQ-1:0]  i_req_datoB,
  input  logic [3*NUM_REQ-1:0]   i_req_operacion,
  output logic [NUM_REQ-1:0]     o_req_accept,
  output logic                   o_rsp_valid,
  output logic [2:0]             o_rsp_id,
  output logic [31:0]            o_rsp_resultado,
  output logic                   o_rsp_error,
  output logic                   o_rsp_timeout,
  output logic                   o_busy,
  output logic [31:0]            o_eng_datoA,
  output logic [31:0]            o_eng_datoB,
  output logic [2:0]             o_eng_operacion,
  output logic                   o_eng_start,
  input  logic [31:0]            i_eng_resultado,
  input  logic                   i_eng_ready,
  input  logic                   i_eng_error
);

  localparam int SCW = $clog2(START_CYCLES + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [SCW-1:0]     r_start_cnt;
  logic [WDW-1:0]     r_wd;
  logic [NUM_REQ-1:0] r_accept;
  logic               r_rsp_valid;
  logic [2:0]         r_rsp_id;
  logic [31:0]        r_rsp_resultado;
  logic               r_rsp_error;
  logic               r_rsp_timeout;
  logic               r_busy;
  logic [31:0]        r_eng_datoA;
  logic [31:0]        r_eng_datoB;
  logic [2:0]         r_eng_operacion;
  logic               r_eng_start;

  logic [2:0]         w_grant;
  logic               w_any;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic [2:0]         w_op;
  logic               w_wd_expired;
  logic [2:0]         w_ptr_next;

  calc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req_valid (i_req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_any       (w_any)
  );

  assign w_a          = 32'(i_req_datoA >> (32 * w_grant));
  assign w_b          = 32'(i_req_datoB >> (32 * w_grant));
  assign w_op         = 3'(i_req_operacion >> (3 * w_grant));
  assign w_wd_expired = (r_wd == WDW'(TIMEOUT - 1));
  assign w_ptr_next   = (r_rsp_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_rsp_id + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_ptr           <= 3'd0;
      r_start_cnt     <= '0;
      r_wd            <= '0;
      r_accept        <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_id        <= 3'd0;
      r_rsp_resultado <= 32'd0;
      r_rsp_error     <= 1'b0;
      r_rsp_timeout   <= 1'b0;
      r_busy          <= 1'b0;
      r_eng_datoA     <= 32'd0;
      r_eng_datoB     <= 32'd0;
      r_eng_operacion <= 3'd0;
      r_eng_start     <= 1'b0;
    end else begin
      r_accept    <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rsp_id <= w_grant;
            r_accept <= ONE << w_grant;
            r_busy   <= 1'b1;
            if (op_rejected(w_op, w_b)) begin
              r_state <= REJECT;
            end else begin
              r_eng_datoA     <= w_a;
              r_eng_datoB     <= w_b;
              r_eng_operacion <= w_op;
              r_eng_start     <= 1'b1;
              r_start_cnt     <= '0;
              r_state         <= LAUNCH;
            end
          end
        end
        REJECT: begin
          r_rsp_valid     <= 1'b1;
          r_rsp_resultado <= 32'd0;
          r_rsp_error     <= 1'b1;
          r_rsp_timeout   <= 1'b0;
          r_state         <= RESPOND;
        end
        LAUNCH: begin
          if (r_start_cnt == SCW'(START_CYCLES - 1)) begin
            r_eng_start <= 1'b0;
            r_wd        <= '0;
            r_state     <= WAIT_BUSY;
          end else begin
            r_start_cnt <= r_start_cnt + SCW'(1);
          end
        end
        WAIT_BUSY: begin
          if (w_wd_expired) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_resultado <= 32'd0;
            r_rsp_error     <= 1'b1;
            r_rsp_timeout   <= 1'b1;
            r_state         <= RESPOND;
          end else begin
            r_wd <= r_wd + WDW'(1);
            if (!i_eng_ready) r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A ready seen on the watchdog's last cycle still counts as completion.
          if (i_eng_ready) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_resultado <= i_eng_resultado;
            r_rsp_error     <= i_eng_error;
            r_rsp_timeout   <= 1'b0;
            r_state         <= RESPOND;
          end else if (w_wd_expired) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_resultado <= 32'd0;
            r_rsp_error     <= 1'b1;
            r_rsp_timeout   <= 1'b1;
            r_state         <= RESPOND;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        RESPOND: begin
          r_ptr   <= w_ptr_next;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_accept    = r_accept;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_id        = r_rsp_id;
  assign o_rsp_resultado = r_rsp_resultado;
  assign o_rsp_error     = r_rsp_error;
  assign o_rsp_timeout   = r_rsp_timeout;
  assign o_busy          = r_busy;
  assign o_eng_datoA     = r_eng_datoA;
  assign o_eng_datoB     = r_eng_datoB;
  assign o_eng_operacion = r_eng_operacion;
  assign o_eng_start     = r_eng_start;

endmodule
